// File: rtl/ccd_block_downsampler_pkg.sv
// Shared types for the CCD block downsampler.
//   state_e : capture FSM states
//   acc_w() : accumulator width able to hold the sum of one block
package ds_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_e;

  function automatic int unsigned acc_w(input int unsigned pix_w, input int unsigned blk_log2);
    return pix_w + 2 * blk_log2;
  endfunction

endpackage

// File: rtl/ccd_block_downsampler_if.sv
// Pixel stream in / image_mem write port out of the block downsampler.
//   iFVAL, iDVAL, iGREY, iX, iY : camera pixel stream with coordinates
//   wr_en, wr_addr, wr_data     : image_mem write port
// slave  = downsampler side, master = camera / memory side.
interface ccd_block_downsampler_if #(
  parameter int unsigned PIX_W  = 12,
  parameter int unsigned ADDR_W = 10
);
  logic              iFVAL;
  logic              iDVAL;
  logic [PIX_W-1:0]  iGREY;
  logic [15:0]       iX;
  logic [15:0]       iY;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output iFVAL, iDVAL, iGREY, iX, iY,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  iFVAL, iDVAL, iGREY, iX, iY,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ccd_block_downsampler_quantise.sv
// Second pipeline stage: block average -> 8-bit pixel with optional
// inversion and binarisation, registered onto the image_mem write port.
//   v_i/avg_i/addr_i  : block result from the accumulate stage
//   invert_i, bin_mode_i, threshold_i : live output controls
//   wr_en_o/wr_addr_o/wr_data_o : registered write port
module ds_quantise #(
  parameter int unsigned PIX_W  = 12,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              D5M_PIXLCLK,
  input  logic              rst_n,
  input  logic              v_i,
  input  logic [PIX_W-1:0]  avg_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              invert_i,
  input  logic              bin_mode_i,
  input  logic [7:0]        threshold_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        v;

  always_comb begin
    v = 8'(avg_i >> (PIX_W - 8));
    if (invert_i)   v = 8'hFF - v;
    if (bin_mode_i) v = (v >= threshold_i) ? 8'hFF : 8'h00;
    wr_en_d   = v_i;
    wr_data_d = v_i ? v : wr_data_q;
    wr_addr_d = v_i ? addr_i : wr_addr_q;
  end

  always_ff @(posedge D5M_PIXLCLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
endmodule

// File: rtl/ccd_block_downsampler.sv
// Streaming grayscale decimator: crops an OUT_W*BLK x OUT_H*BLK window from
// the camera stream, box-averages each BLK x BLK block and writes one 8-bit
// pixel per block to image_mem. Single-frame capture on request; a frame
// that ends early is dropped and the next frame is captured instead.
//   D5M_PIXLCLK, rst_n : pixel clock, async active-low reset
//   bus                : pixel stream in, image_mem write port out
//   capture_req        : arm a capture (only looked at in IDLE)
//   invert, bin_mode, threshold : output pixel shaping
//   busy, frame_done, frame_cnt : capture status
module ccd_block_downsampler
  import ds_pkg::*;
#(
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned BLK_LOG2 = 4,
  parameter int unsigned OUT_W    = 28,
  parameter int unsigned OUT_H    = 28,
  parameter int unsigned CROP_X0  = 96,
  parameter int unsigned CROP_Y0  = 16,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                    D5M_PIXLCLK,
  input  logic                    rst_n,
  ccd_block_downsampler_if.slave  bus,
  input  logic                    capture_req,
  input  logic                    invert,
  input  logic                    bin_mode,
  input  logic [7:0]              threshold,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              frame_cnt
);
  localparam int unsigned ACC_W = acc_w(PIX_W, BLK_LOG2);
  localparam int unsigned X_END = CROP_X0 + (OUT_W << BLK_LOG2);
  localparam int unsigned Y_END = CROP_Y0 + (OUT_H << BLK_LOG2);
  localparam int unsigned OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W * OUT_H - 1);

  state_e            state_q, state_d;
  logic              fval_q, fval_rise, fval_fall;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              in_win, accept, first_pix, last_pix, last_write;
  logic [15:0]       dx, dy;
  logic [OX_W-1:0]   ox;
  logic [OY_W-1:0]   oy;
  logic [BLK_LOG2-1:0] sub_col, sub_row;
  logic [ACC_W-1:0]  acc_q [OUT_W];
  logic [ACC_W-1:0]  sum, acc_d;
  logic              s1_v_q, s1_v_d;
  logic [PIX_W-1:0]  s1_avg_q, s1_avg_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

  // Window, offsets and accumulate-stage next values
  always_comb begin
    in_win = (32'(bus.iX) >= CROP_X0) && (32'(bus.iX) < X_END) &&
             (32'(bus.iY) >= CROP_Y0) && (32'(bus.iY) < Y_END);
    accept    = (state_q == CAPTURE) && bus.iDVAL && in_win;
    dx        = bus.iX - 16'(CROP_X0);
    dy        = bus.iY - 16'(CROP_Y0);
    ox        = OX_W'(dx >> BLK_LOG2);
    oy        = OY_W'(dy >> BLK_LOG2);
    sub_col   = dx[BLK_LOG2-1:0];
    sub_row   = dy[BLK_LOG2-1:0];
    first_pix = (sub_col == '0) && (sub_row == '0);
    last_pix  = (sub_col == '1) && (sub_row == '1);
    sum       = acc_q[ox] + ACC_W'(bus.iGREY);
    // The block's first pixel overwrites, so stale sums never need clearing
    acc_d     = first_pix ? ACC_W'(bus.iGREY) : sum;
    s1_v_d    = accept && last_pix;
    s1_avg_d  = s1_v_d ? PIX_W'(sum >> (2 * BLK_LOG2)) : s1_avg_q;
    s1_addr_d = s1_v_d ? (ADDR_W'(oy) * ADDR_W'(OUT_W) + ADDR_W'(ox)) : s1_addr_q;
  end

  always_ff @(posedge D5M_PIXLCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OUT_W; i++) acc_q[i] <= '0;
    end else if (accept) begin
      acc_q[ox] <= acc_d;
    end
  end

  always_ff @(posedge D5M_PIXLCLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_avg_q  <= '0;
      s1_addr_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_avg_q  <= s1_avg_d;
      s1_addr_q <= s1_addr_d;
    end
  end

  ds_quantise #(
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_quant (
    .D5M_PIXLCLK (D5M_PIXLCLK),
    .rst_n       (rst_n),
    .v_i         (s1_v_q),
    .avg_i       (s1_avg_q),
    .addr_i      (s1_addr_q),
    .invert_i    (invert),
    .bin_mode_i  (bin_mode),
    .threshold_i (threshold),
    .wr_en_o     (bus.wr_en),
    .wr_addr_o   (bus.wr_addr),
    .wr_data_o   (bus.wr_data)
  );

  // FSM: state register
  always_ff @(posedge D5M_PIXLCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fval_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fval_q      <= bus.iFVAL;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // FSM: next state. The final write wins over a same-cycle FVAL drop.
  always_comb begin
    fval_rise  = bus.iFVAL && !fval_q;
    fval_fall  = !bus.iFVAL && fval_q;
    last_write = bus.wr_en && (bus.wr_addr == LAST_ADDR);
    state_d    = state_q;
    unique case (state_q)
      IDLE:    if (capture_req) state_d = ARMED;
      ARMED:   if (fval_rise)   state_d = CAPTURE;
      CAPTURE: begin
        if (last_write)     state_d = DONE;
        else if (fval_fall) state_d = ARMED;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy        = (state_q == ARMED) || (state_q == CAPTURE);
    frame_done  = (state_q == DONE);
    frame_cnt_d = (state_q == DONE) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    frame_cnt   = frame_cnt_q;
  end
endmodule
